counter_sched: RTL and testbench
================================

// Module: counter_sched
// PURPOSE
//  Two-requester scheduler for the 4-bit counter. Arbitrates round-robin between two command ports.
//  Sequences the granted job: load D, run LEN cycles in the job MODO, drain, report.
//  Reports final Q, the number of RCO pulses and a load-check flag. Sits directly in front of the counter's ENABLE/RESET/MODO/D inputs.
// PARAMETERS
//  LEN_W  8  width of run length and of RCO pulse counter
// PORTS
//  CLK        in   1      clock; all logic on posedge
//  RESET      in   1      synchronous, active-high; clears all state
//  REQ0_VALID in   1      requester 0 job present
//  REQ0_MODO  in   2      job count mode (`CUENTA_* / `CARGA_D codes)
//  REQ0_D     in   4      job start value
//  REQ0_LEN   in   LEN_W  job run cycles
//  REQ0_READY out  1      job accepted when VALID&&READY
//  REQ1_*     --   --     identical set for requester 1
//  CNT_ENABLE out  1      to counter ENABLE
//  CNT_RESET  out  1      to counter RESET (1 = clear, 0 = run)
//  CNT_MODO   out  2      to counter MODO
//  CNT_D      out  4      to counter D
//  CNT_Q      in   4      from counter Q
//  CNT_RCO    in   1      from counter RCO
//  CNT_LOAD   in   1      from counter LOAD
//  BUSY       out  1      1 in any state but IDLE
//  DONE       out  1      one-cycle pulse, result valid
//  DONE_ID    out  1      requester of finished job
//  RESULT_Q   out  4      CNT_Q sampled in DRAIN
//  RCO_CNT    out  LEN_W  RCO pulses seen in RUN+DRAIN, saturating at all-ones
//  LOAD_ERR   out  1      load check failed for this job
// BEHAVIOUR
//  Reset values: READYs 0, CNT_ENABLE 0, CNT_RESET 1, CNT_MODO `CARGA_D, CNT_D 0.
//  Also at reset: BUSY, DONE, DONE_ID, RESULT_Q, RCO_CNT, LOAD_ERR all 0. RR pointer favours REQ0.
//  FSM IDLE->LOAD->RUN->DRAIN->DONE->IDLE; LOAD->DRAIN directly when LEN==0.
//  IDLE: CNT_ENABLE=0, CNT_RESET=1 (counter held at 0).
//   READY is combinational: asserted only for the arbitration winner among VALID ports, and only in IDLE.
//   Both valid: winner = port not granted last; pointer updates on each accept.
//   Accept latches MODO/D/LEN/ID and clears RCO_CNT and LOAD_ERR. VALID dropping before accept is legal; nothing latched.
//  LOAD (1 cycle): ENABLE=1, RESET=0, MODO=`CARGA_D, D=latched D.
//  RUN (LEN cycles): ENABLE=1, RESET=0, MODO=latched MODO; down-counter of LEN.
//  DRAIN (1 cycle): ENABLE=0, RESET=1. Samples CNT_Q into RESULT_Q; last RCO is counted here.
//  DONE (1 cycle): DONE=1, DONE_ID=latched ID. RESULT_Q/RCO_CNT/LOAD_ERR hold until next accept.
//  RCO count: +1 every RUN or DRAIN cycle with CNT_RCO=1 (counter is 1-cycle registered).
//  Load check: in first cycle after LOAD (RUN1 or DRAIN), require CNT_LOAD=1 and CNT_Q==latched D; else LOAD_ERR=1.
//  Latency: accept at t -> DONE at t+3+LEN. Jobs never overlap; next accept earliest in IDLE at t+4+LEN.
//  RESET mid-job: next cycle IDLE with reset values, job dropped, no DONE.
//  LEN max (all-ones) and RCO_CNT wrap: no rollover, saturate.
// TESTING
//  1 REQ0 `CUENTA_MAS_UNO, D=E, LEN=3 -> Q E,F,0,1. Expect RESULT_Q=1, RCO_CNT=1, LOAD_ERR=0, DONE at t+6, DONE_ID=0.
//  2 REQ1 `CUENTA_TRES_TRES, D=2, LEN=2 -> Q F then C. Expect RESULT_Q=C, RCO_CNT=1, DONE_ID=1.
//  3 Both VALID after reset -> REQ0 accepted first, REQ1 accepted at next IDLE.
//    Both held VALID again -> REQ0 granted (alternation).
//  4 REQ0 LEN=0, D=9 -> RESULT_Q=9, RCO_CNT=0, DONE at t+3.
//  5 RESET=1 in RUN cycle 2 of LEN=5 job -> next cycle BUSY=0, CNT_RESET=1, no DONE pulse.
//    Queued REQ1 is accepted afterwards with REQ0 priority restored.
//  6 Stub counter holding CNT_LOAD=0 -> LOAD_ERR=1 on DONE; job still completes at t+3+LEN.

Source files
------------

// File: rtl/counter_sched.sv
// Two-requester round-robin scheduler in front of the 4-bit counter.
// A job loads D, runs LEN cycles in its mode, drains, then reports Q, RCO pulses and a load check.
module counter_sched #(
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0_VALID,
  input  logic [1:0]       REQ0_MODO,
  input  logic [3:0]       REQ0_D,
  input  logic [LEN_W-1:0] REQ0_LEN,
  output logic             REQ0_READY,
  input  logic             REQ1_VALID,
  input  logic [1:0]       REQ1_MODO,
  input  logic [3:0]       REQ1_D,
  input  logic [LEN_W-1:0] REQ1_LEN,
  output logic             REQ1_READY,
  output logic             CNT_ENABLE,
  output logic             CNT_RESET,
  output logic [1:0]       CNT_MODO,
  output logic [3:0]       CNT_D,
  input  logic [3:0]       CNT_Q,
  input  logic             CNT_RCO,
  input  logic             CNT_LOAD,
  output logic             BUSY,
  output logic             DONE,
  output logic             DONE_ID,
  output logic [3:0]       RESULT_Q,
  output logic [LEN_W-1:0] RCO_CNT,
  output logic             LOAD_ERR
);

  localparam logic [1:0] CARGA_D = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic             last_grant;
  logic             pick1;
  logic             accept;
  logic             check_pending;
  logic [1:0]       job_modo;
  logic [3:0]       job_d;
  logic [LEN_W-1:0] len_left;
  logic             job_id;

  // With both ports valid the one not granted last wins; otherwise the only valid port wins.
  always_comb begin
    if (REQ0_VALID && REQ1_VALID) pick1 = ~last_grant;
    else                          pick1 = REQ1_VALID;
  end

  assign REQ0_READY = (state == S_IDLE) && !RESET && REQ0_VALID && !pick1;
  assign REQ1_READY = (state == S_IDLE) && !RESET && REQ1_VALID && pick1;
  assign accept     = REQ0_READY || REQ1_READY;

  assign BUSY    = (state != S_IDLE);
  assign DONE    = (state == S_DONE);
  assign DONE_ID = DONE && job_id;

  always_comb begin
    CNT_ENABLE = 1'b0;
    CNT_RESET  = 1'b1;
    CNT_MODO   = CARGA_D;
    CNT_D      = 4'h0;
    case (state)
      S_LOAD: begin
        CNT_ENABLE = 1'b1;
        CNT_RESET  = 1'b0;
        CNT_D      = job_d;
      end
      S_RUN: begin
        CNT_ENABLE = 1'b1;
        CNT_RESET  = 1'b0;
        CNT_MODO   = job_modo;
      end
      default: ;
    endcase
  end

  // The counter output lags one cycle, so the load check and the last RCO land after LOAD/RUN.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= S_IDLE;
      last_grant    <= 1'b1;
      job_modo      <= 2'b00;
      job_d         <= 4'h0;
      len_left      <= '0;
      job_id        <= 1'b0;
      check_pending <= 1'b0;
      RESULT_Q      <= 4'h0;
      RCO_CNT       <= '0;
      LOAD_ERR      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            job_modo   <= pick1 ? REQ1_MODO : REQ0_MODO;
            job_d      <= pick1 ? REQ1_D    : REQ0_D;
            len_left   <= pick1 ? REQ1_LEN  : REQ0_LEN;
            job_id     <= pick1;
            last_grant <= pick1;
            RCO_CNT    <= '0;
            LOAD_ERR   <= 1'b0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          check_pending <= 1'b1;
          state         <= (len_left == '0) ? S_DRAIN : S_RUN;
        end
        S_RUN: begin
          check_pending <= 1'b0;
          len_left      <= len_left - LEN_W'(1);
          if (len_left == LEN_W'(1)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          check_pending <= 1'b0;
          RESULT_Q      <= CNT_Q;
          state         <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if ((state == S_RUN || state == S_DRAIN) && CNT_RCO && (RCO_CNT != '1))
        RCO_CNT <= RCO_CNT + LEN_W'(1);

      if (check_pending && (!CNT_LOAD || (CNT_Q != job_d)))
        LOAD_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: a behavioural 4-bit counter stub, a job table and a DONE scoreboard.
`timescale 1ns/1ps
module tb_counter_sched;

  localparam int LEN_W = 8;
  localparam logic [1:0] CUENTA_MAS_UNO   = 2'b00;
  localparam logic [1:0] CUENTA_MENOS_UNO = 2'b01;
  localparam logic [1:0] CUENTA_TRES_TRES = 2'b10;
  localparam logic [1:0] CARGA_D          = 2'b11;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             REQ0_VALID, REQ1_VALID;
  logic [1:0]       REQ0_MODO, REQ1_MODO;
  logic [3:0]       REQ0_D, REQ1_D;
  logic [LEN_W-1:0] REQ0_LEN, REQ1_LEN;
  logic             REQ0_READY, REQ1_READY;
  logic             CNT_ENABLE, CNT_RESET;
  logic [1:0]       CNT_MODO;
  logic [3:0]       CNT_D, CNT_Q;
  logic             CNT_RCO, CNT_LOAD;
  logic             BUSY, DONE, DONE_ID;
  logic [3:0]       RESULT_Q;
  logic [LEN_W-1:0] RCO_CNT;
  logic             LOAD_ERR;

  typedef struct {
    logic             port;
    logic [1:0]       modo;
    logic [3:0]       d;
    logic [LEN_W-1:0] len;
    logic             no_load;
    logic             rco_stuck;
    logic [3:0]       exp_q;
    logic [LEN_W-1:0] exp_rco;
    logic             exp_err;
  } vec_t;

  typedef struct {
    logic             id;
    logic [3:0]       q;
    logic [LEN_W-1:0] rco;
    logic             err;
    int               len;
    int               accept_cyc;
  } exp_t;

  int   assert_count = 0;
  int   fail_count   = 0;
  int   cyc          = 0;
  int   done_seen    = 0;
  exp_t sb_q[$];
  exp_t pend0, pend1;

  counter_sched #(.LEN_W(LEN_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_MODO(REQ0_MODO), .REQ0_D(REQ0_D), .REQ0_LEN(REQ0_LEN), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_MODO(REQ1_MODO), .REQ1_D(REQ1_D), .REQ1_LEN(REQ1_LEN), .REQ1_READY(REQ1_READY),
    .CNT_ENABLE(CNT_ENABLE), .CNT_RESET(CNT_RESET), .CNT_MODO(CNT_MODO), .CNT_D(CNT_D),
    .CNT_Q(CNT_Q), .CNT_RCO(CNT_RCO), .CNT_LOAD(CNT_LOAD),
    .BUSY(BUSY), .DONE(DONE), .DONE_ID(DONE_ID),
    .RESULT_Q(RESULT_Q), .RCO_CNT(RCO_CNT), .LOAD_ERR(LOAD_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Registered counter stub; knobs can suppress LOAD or pin RCO high.
  logic [3:0] stub_q = 4'h0;
  logic       stub_rco = 1'b0, stub_load = 1'b0;
  logic       stub_no_load = 1'b0, stub_rco_stuck = 1'b0;

  always @(posedge CLK) begin
    if (CNT_RESET) begin
      stub_q <= 4'h0; stub_rco <= 1'b0; stub_load <= 1'b0;
    end else if (CNT_ENABLE) begin
      stub_rco  <= 1'b0;
      stub_load <= 1'b0;
      case (CNT_MODO)
        CARGA_D:          begin stub_q <= CNT_D;         stub_load <= !stub_no_load;     end
        CUENTA_MAS_UNO:   begin stub_q <= stub_q + 4'd1; stub_rco  <= (stub_q == 4'hF); end
        CUENTA_MENOS_UNO: begin stub_q <= stub_q - 4'd1; stub_rco  <= (stub_q == 4'h0); end
        default:          begin stub_q <= stub_q - 4'd3; stub_rco  <= (stub_q < 4'd3);  end
      endcase
    end else begin
      stub_rco <= 1'b0; stub_load <= 1'b0;
    end
  end

  assign CNT_Q    = stub_q;
  assign CNT_RCO  = stub_rco | stub_rco_stuck;
  assign CNT_LOAD = stub_load;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Accepts push the pending job's expectation; each DONE pops and checks one.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (!RESET && REQ0_VALID && REQ0_READY) begin e = pend0; e.accept_cyc = cyc; sb_q.push_back(e); end
    if (!RESET && REQ1_VALID && REQ1_READY) begin e = pend1; e.accept_cyc = cyc; sb_q.push_back(e); end
    if (DONE === 1'b1) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_done", DONE, 1'b0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("done_id",  DONE_ID,  e.id);
        checkOutput("result_q", RESULT_Q, e.q);
        checkOutput("rco_cnt",  RCO_CNT,  e.rco);
        checkOutput("load_err", LOAD_ERR, e.err);
        checkOutput("latency",  cyc - e.accept_cyc, 3 + e.len);
      end
    end
  end

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b1; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   n;
    int   d0;
    e = '{id:v.port, q:v.exp_q, rco:v.exp_rco, err:v.exp_err, len:int'(v.len), accept_cyc:0};
    @(posedge CLK); #1;
    stub_no_load = v.no_load;
    stub_rco_stuck = v.rco_stuck;
    if (v.port) begin
      pend1 = e; REQ1_MODO = v.modo; REQ1_D = v.d; REQ1_LEN = v.len; REQ1_VALID = 1'b1;
    end else begin
      pend0 = e; REQ0_MODO = v.modo; REQ0_D = v.d; REQ0_LEN = v.len; REQ0_VALID = 1'b1;
    end
    d0 = done_seen;
    n = 0;
    do begin @(negedge CLK); n++; end
    while (!(v.port ? REQ1_READY : REQ0_READY) && n < 50);
    checkOutput("ready_seen", v.port ? REQ1_READY : REQ0_READY, 1'b1);
    @(posedge CLK); #1;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    @(negedge CLK);
    checkOutput("load_drive", {BUSY, CNT_ENABLE, CNT_RESET, CNT_MODO, CNT_D}, {1'b1, 1'b1, 1'b0, CARGA_D, v.d});
    if (v.len != '0) begin
      @(negedge CLK);
      checkOutput("run_modo", {CNT_ENABLE, CNT_RESET, CNT_MODO}, {1'b1, 1'b0, v.modo});
    end
    n = 0;
    while (done_seen == d0 && n < int'(v.len) + 10) begin @(negedge CLK); n++; end
    checkOutput("done_seen", done_seen - d0, 1);
    @(negedge CLK);
    checkOutput("idle_hold", {BUSY, DONE, RESULT_Q, RCO_CNT, LOAD_ERR}, {1'b0, 1'b0, v.exp_q, v.exp_rco, v.exp_err});
    stub_no_load = 1'b0;
    stub_rco_stuck = 1'b0;
  endtask

  // Both ports held valid; grants must alternate starting with REQ0, spaced LEN+4 apart.
  task automatic run_arbitration(input int n_grants);
    int n;
    int prev_t;
    prev_t = -1;
    @(posedge CLK); #1;
    pend0 = '{id:1'b0, q:4'h4, rco:8'd0, err:1'b0, len:1, accept_cyc:0};
    pend1 = '{id:1'b1, q:4'h0, rco:8'd1, err:1'b0, len:1, accept_cyc:0};
    REQ0_MODO = CUENTA_MAS_UNO; REQ0_D = 4'h3; REQ0_LEN = 8'd1; REQ0_VALID = 1'b1;
    REQ1_MODO = CUENTA_MAS_UNO; REQ1_D = 4'hF; REQ1_LEN = 8'd1; REQ1_VALID = 1'b1;
    for (int k = 0; k < n_grants; k++) begin
      n = 0;
      do begin @(negedge CLK); n++; end
      while (!(REQ0_READY || REQ1_READY) && n < 20);
      checkOutput("arb_grant", {REQ1_READY, REQ0_READY}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (prev_t >= 0) checkOutput("arb_spacing", cyc - prev_t, 5);
      prev_t = cyc;
    end
    @(posedge CLK); #1;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    n = 0;
    do begin @(negedge CLK); n++; end
    while (BUSY && n < 20);
    checkOutput("arb_idle", BUSY, 1'b0);
  endtask

  initial begin
    vec_t vecs[9];
    int   n;
    vecs[0] = '{port:1'b0, modo:CUENTA_MAS_UNO,   d:4'hE, len:8'd3,   no_load:1'b0, rco_stuck:1'b0, exp_q:4'h1, exp_rco:8'd1,   exp_err:1'b0};
    vecs[1] = '{port:1'b1, modo:CUENTA_TRES_TRES, d:4'h2, len:8'd2,   no_load:1'b0, rco_stuck:1'b0, exp_q:4'hC, exp_rco:8'd1,   exp_err:1'b0};
    vecs[2] = '{port:1'b0, modo:CUENTA_MAS_UNO,   d:4'h9, len:8'd0,   no_load:1'b0, rco_stuck:1'b0, exp_q:4'h9, exp_rco:8'd0,   exp_err:1'b0};
    vecs[3] = '{port:1'b1, modo:CUENTA_MENOS_UNO, d:4'h1, len:8'd4,   no_load:1'b0, rco_stuck:1'b0, exp_q:4'hD, exp_rco:8'd1,   exp_err:1'b0};
    vecs[4] = '{port:1'b0, modo:CUENTA_MAS_UNO,   d:4'hD, len:8'd3,   no_load:1'b0, rco_stuck:1'b0, exp_q:4'h0, exp_rco:8'd1,   exp_err:1'b0};
    vecs[5] = '{port:1'b1, modo:CUENTA_TRES_TRES, d:4'h0, len:8'd16,  no_load:1'b0, rco_stuck:1'b0, exp_q:4'h0, exp_rco:8'd3,   exp_err:1'b0};
    vecs[6] = '{port:1'b0, modo:CUENTA_MAS_UNO,   d:4'h5, len:8'd2,   no_load:1'b1, rco_stuck:1'b0, exp_q:4'h7, exp_rco:8'd0,   exp_err:1'b1};
    vecs[7] = '{port:1'b1, modo:CUENTA_MAS_UNO,   d:4'h0, len:8'd255, no_load:1'b0, rco_stuck:1'b1, exp_q:4'hF, exp_rco:8'd255, exp_err:1'b0};
    vecs[8] = '{port:1'b0, modo:CUENTA_TRES_TRES, d:4'hF, len:8'd10,  no_load:1'b0, rco_stuck:1'b0, exp_q:4'h1, exp_rco:8'd1,   exp_err:1'b0};

    RESET = 1'b1;
    REQ0_VALID = 1'b0; REQ0_MODO = 2'b00; REQ0_D = 4'h0; REQ0_LEN = '0;
    REQ1_VALID = 1'b0; REQ1_MODO = 2'b00; REQ1_D = 4'h0; REQ1_LEN = '0;
    do_reset();

    @(negedge CLK);
    checkOutput("rst_ready", {REQ1_READY, REQ0_READY}, 2'b00);
    checkOutput("rst_cnt", {CNT_ENABLE, CNT_RESET, CNT_MODO, CNT_D}, {1'b0, 1'b1, CARGA_D, 4'h0});
    checkOutput("rst_status", {BUSY, DONE, DONE_ID, LOAD_ERR}, 4'b0000);
    checkOutput("rst_results", {RESULT_Q, RCO_CNT}, 12'h000);

    $display("[TB] job table");
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    $display("[TB] arbitration after reset");
    do_reset();
    run_arbitration(3);

    $display("[TB] reset in the middle of a job");
    @(posedge CLK); #1;
    pend0 = '{id:1'b0, q:4'h0, rco:8'd0, err:1'b0, len:5, accept_cyc:0};
    REQ0_MODO = CUENTA_MAS_UNO; REQ0_D = 4'h0; REQ0_LEN = 8'd5; REQ0_VALID = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end
    while (!REQ0_READY && n < 20);
    checkOutput("mid_ready", REQ0_READY, 1'b1);
    @(posedge CLK); #1;
    REQ0_VALID = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #1;
    RESET = 1'b1;
    sb_q.delete();
    @(negedge CLK);
    checkOutput("mid_busy", {BUSY, CNT_ENABLE}, 2'b11);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("mid_after", {BUSY, CNT_ENABLE, CNT_RESET}, 3'b001);
    checkOutput("mid_results", {RESULT_Q, RCO_CNT, LOAD_ERR}, 13'h0);
    repeat (8) begin
      @(negedge CLK);
      checkOutput("mid_no_done", DONE, 1'b0);
    end
    run_arbitration(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: time limit reached, %0d failures so far", fail_count);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
